// File: rtl/hazard_ctrl_if.sv
// Pipeline-side hazard interface: decode/execute/memory status in, stall/bubble/flush enables and counters out.
// The sequencer owns the slave modport; the pipeline (or a bench) owns the master modport.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [4:0]       id_rs1_num;
  logic [4:0]       id_rs2_num;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic             ex_valid;
  logic [6:0]       ex_opcode;
  logic [4:0]       ex_rd_num;
  logic             redirect;
  logic             mem_op;
  logic             mem_ready;
  logic             pc_stall;
  logic             if_id_stall;
  logic             id_ex_bubble;
  logic             ex_mem_stall;
  logic             if_id_flush;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport slave (
    input  id_valid, id_rs1_num, id_rs2_num, id_uses_rs1, id_uses_rs2,
    input  ex_valid, ex_opcode, ex_rd_num, redirect, mem_op, mem_ready,
    output pc_stall, if_id_stall, id_ex_bubble, ex_mem_stall, if_id_flush,
    output stall_cnt, flush_cnt
  );

  modport master (
    output id_valid, id_rs1_num, id_rs2_num, id_uses_rs1, id_uses_rs2,
    output ex_valid, ex_opcode, ex_rd_num, redirect, mem_op, mem_ready,
    input  pc_stall, if_id_stall, id_ex_bubble, ex_mem_stall, if_id_flush,
    input  stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Execute-stage sequencer: zero-latency (Mealy) stall/bubble/flush enables for load-use, memory waits and redirects.
// Memory wait outranks redirect outranks load-use; perf counters are registered and saturate.
module hazard_ctrl #(
  parameter int LU_CYCLES    = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  hz
);

  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam int MAXC = (LU_CYCLES > FLUSH_CYCLES) ? LU_CYCLES : FLUSH_CYCLES;
  localparam int CW   = (MAXC < 2) ? 1 : $clog2(MAXC + 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2,
    FLUSH    = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             redir_pend_q, redir_pend_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic mem_wait, ex_redir, load_use;
  logic pc_stall, if_id_stall, id_ex_bubble, ex_mem_stall, if_id_flush;
  logic flush_apply;

  assign mem_wait = hz.mem_op & ~hz.mem_ready;
  assign ex_redir = hz.ex_valid & hz.redirect;
  // x0 is never a real producer, so it can never create a load-use dependency
  assign load_use = hz.ex_valid & (hz.ex_opcode == OP_LOAD) & (hz.ex_rd_num != 5'd0) & hz.id_valid &
                    ((hz.id_uses_rs1 & (hz.id_rs1_num == hz.ex_rd_num)) |
                     (hz.id_uses_rs2 & (hz.id_rs2_num == hz.ex_rd_num)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      cnt_q        <= '0;
      redir_pend_q <= 1'b0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      redir_pend_q <= redir_pend_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    redir_pend_d = redir_pend_q;
    case (state_q)
      RUN: begin
        if (mem_wait) begin
          state_d      = MEM_WAIT;
          redir_pend_d = ex_redir;
        end else if (ex_redir) begin
          if (FLUSH_CYCLES > 1) begin
            cnt_d   = CW'(FLUSH_CYCLES - 1);
            state_d = FLUSH;
          end
        end else if (load_use) begin
          if (LU_CYCLES > 1) begin
            cnt_d   = CW'(LU_CYCLES - 1);
            state_d = LU_STALL;
          end
        end
      end
      LU_STALL: begin
        if (mem_wait) begin
          state_d      = MEM_WAIT;
          redir_pend_d = ex_redir;
        end else begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = RUN;
        end
      end
      MEM_WAIT: begin
        if (hz.mem_ready) begin
          redir_pend_d = 1'b0;
          if (redir_pend_q && (FLUSH_CYCLES > 1)) begin
            cnt_d   = CW'(FLUSH_CYCLES - 1);
            state_d = FLUSH;
          end else begin
            state_d = RUN;
          end
        end
      end
      FLUSH: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    id_ex_bubble = 1'b0;
    ex_mem_stall = 1'b0;
    if_id_flush  = 1'b0;
    flush_apply  = 1'b0;
    if (!rst) begin
      case (state_q)
        RUN: begin
          if (mem_wait) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            ex_mem_stall = 1'b1;
          end else if (ex_redir) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            flush_apply  = 1'b1;
          end else if (load_use) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_bubble = 1'b1;
          end
        end
        LU_STALL: begin
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          if (mem_wait) ex_mem_stall = 1'b1;
          else          id_ex_bubble = 1'b1;
        end
        MEM_WAIT: begin
          if (!hz.mem_ready) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            ex_mem_stall = 1'b1;
          end else if (redir_pend_q) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            flush_apply  = 1'b1;
          end
        end
        // EX holds a bubble here, so any redirect input is stale and ignored
        FLUSH:   if_id_flush = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (pc_stall && !(&stall_cnt_q))    stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush_apply && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  assign hz.pc_stall     = pc_stall;
  assign hz.if_id_stall  = if_id_stall;
  assign hz.id_ex_bubble = id_ex_bubble;
  assign hz.ex_mem_stall = ex_mem_stall;
  assign hz.if_id_flush  = if_id_flush;
  assign hz.stall_cnt    = stall_cnt_q;
  assign hz.flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboarded bench: dut0 uses default parameters, dut1 uses LU_CYCLES=2, FLUSH_CYCLES=3 and 2-bit counters.
// Each step drives one DUT (the other idles) and queues hand-computed control outputs plus counter expectations.
module tb_hazard_ctrl;

  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_ALU  = 7'b0110011;
  // {pc_stall, if_id_stall, id_ex_bubble, ex_mem_stall, if_id_flush}
  localparam logic [4:0] NONE = 5'b00000;
  localparam logic [4:0] MEMW = 5'b11010;
  localparam logic [4:0] LUS  = 5'b11100;
  localparam logic [4:0] RDR  = 5'b00101;
  localparam logic [4:0] FL   = 5'b00001;

  typedef struct packed {
    logic       id_valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       ex_valid;
    logic [6:0] opc;
    logic [4:0] rd;
    logic       redirect;
    logic       mem_op;
    logic       mem_ready;
  } stim_t;

  typedef struct {
    int          tag;
    logic [4:0]  c0;
    logic [4:0]  c1;
    logic [15:0] s0, f0, s1, f1;
    bit          cnt_ok;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(16)) if0 ();
  hazard_ctrl_if #(.CNT_W(2))  if1 ();

  hazard_ctrl #(.LU_CYCLES(1), .FLUSH_CYCLES(1), .CNT_W(16)) dut0 (.clk(clk), .rst(rst), .hz(if0.slave));
  hazard_ctrl #(.LU_CYCLES(2), .FLUSH_CYCLES(3), .CNT_W(2))  dut1 (.clk(clk), .rst(rst), .hz(if1.slave));

  exp_t        expq[$];
  int          n_chk = 0;
  int          n_err = 0;
  logic [15:0] acc_s[2];
  logic [15:0] acc_f[2];
  bit          cnt_known = 1'b0;

  function automatic stim_t mk(logic idv, logic [4:0] r1, logic [4:0] r2, logic u1, logic u2,
                               logic exv, logic [6:0] op, logic [4:0] rd,
                               logic rdr, logic mop, logic mrdy);
    stim_t s;
    s.id_valid = idv; s.rs1 = r1; s.rs2 = r2; s.u1 = u1; s.u2 = u2;
    s.ex_valid = exv; s.opc = op; s.rd = rd;
    s.redirect = rdr; s.mem_op = mop; s.mem_ready = mrdy;
    return s;
  endfunction

  task automatic drive0(input stim_t s);
    if0.id_valid = s.id_valid; if0.id_rs1_num = s.rs1; if0.id_rs2_num = s.rs2;
    if0.id_uses_rs1 = s.u1; if0.id_uses_rs2 = s.u2; if0.ex_valid = s.ex_valid;
    if0.ex_opcode = s.opc; if0.ex_rd_num = s.rd; if0.redirect = s.redirect;
    if0.mem_op = s.mem_op; if0.mem_ready = s.mem_ready;
  endtask

  task automatic drive1(input stim_t s);
    if1.id_valid = s.id_valid; if1.id_rs1_num = s.rs1; if1.id_rs2_num = s.rs2;
    if1.id_uses_rs1 = s.u1; if1.id_uses_rs2 = s.u2; if1.ex_valid = s.ex_valid;
    if1.ex_opcode = s.opc; if1.ex_rd_num = s.rd; if1.redirect = s.redirect;
    if1.mem_op = s.mem_op; if1.mem_ready = s.mem_ready;
  endtask

  task automatic bump(input int i, input logic [4:0] c);
    logic [15:0] maxv;
    maxv = (i == 0) ? 16'hFFFF : 16'h0003;
    if (c[4] && acc_s[i] < maxv) acc_s[i] = acc_s[i] + 16'd1;
    if (c[2] && c[0] && acc_f[i] < maxv) acc_f[i] = acc_f[i] + 16'd1;
  endtask

  // One clock cycle of stimulus on DUT d with its expected control outputs
  task automatic step(input int tag, input int d, input logic r, input stim_t s, input logic [4:0] e);
    exp_t x;
    @(posedge clk);
    #1;
    rst = r;
    drive0((d == 0) ? s : '0);
    drive1((d == 1) ? s : '0);
    x.tag = tag;
    x.c0 = (r || d != 0) ? NONE : e;
    x.c1 = (r || d != 1) ? NONE : e;
    x.s0 = acc_s[0]; x.f0 = acc_f[0]; x.s1 = acc_s[1]; x.f1 = acc_f[1];
    x.cnt_ok = cnt_known;
    expq.push_back(x);
    if (r) begin
      acc_s[0] = '0; acc_f[0] = '0; acc_s[1] = '0; acc_f[1] = '0;
      cnt_known = 1'b1;
    end else begin
      bump(0, x.c0);
      bump(1, x.c1);
    end
  endtask

  task automatic chk(input int tag, input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL step %0d %s: got %h expected %h", tag, name, act, exp);
    end
  endtask

  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        x = expq.pop_front();
        chk(x.tag, "ctrl0", {11'd0, if0.pc_stall, if0.if_id_stall, if0.id_ex_bubble,
                             if0.ex_mem_stall, if0.if_id_flush}, {11'd0, x.c0});
        chk(x.tag, "ctrl1", {11'd0, if1.pc_stall, if1.if_id_stall, if1.id_ex_bubble,
                             if1.ex_mem_stall, if1.if_id_flush}, {11'd0, x.c1});
        if (x.cnt_ok) begin
          chk(x.tag, "stall_cnt0", if0.stall_cnt, x.s0);
          chk(x.tag, "flush_cnt0", if0.flush_cnt, x.f0);
          chk(x.tag, "stall_cnt1", {14'd0, if1.stall_cnt}, x.s1);
          chk(x.tag, "flush_cnt1", {14'd0, if1.flush_cnt}, x.f1);
        end
      end
    end
  end

  initial begin
    stim_t idle, lu5, all3, mw, mr, rdr;
    idle = '0;
    lu5  = mk(1, 5'd1, 5'd5, 1, 1, 1, OP_LOAD, 5'd5, 0, 0, 0);
    all3 = mk(1, 5'd5, 5'd2, 1, 1, 1, OP_LOAD, 5'd5, 1, 1, 0);
    mw   = mk(0, 5'd0, 5'd0, 0, 0, 0, OP_ALU, 5'd0, 0, 1, 0);
    mr   = mk(0, 5'd0, 5'd0, 0, 0, 0, OP_ALU, 5'd0, 0, 1, 1);
    rdr  = mk(0, 5'd0, 5'd0, 0, 0, 1, OP_ALU, 5'd3, 1, 0, 0);
    drive0(idle);
    drive1(idle);
    acc_s[0] = '0; acc_f[0] = '0; acc_s[1] = '0; acc_f[1] = '0;

    step(1, 0, 1, idle, NONE);
    step(2, 0, 1, idle, NONE);
    // load-use on rs2, single-cycle stall
    step(10, 0, 0, lu5, LUS);
    step(11, 0, 0, idle, NONE);
    // no hazard: rd=x0, unused rs1 match, non-load producer, empty decode slot
    step(20, 0, 0, mk(1, 5'd0, 5'd0, 1, 1, 1, OP_LOAD, 5'd0, 0, 0, 0), NONE);
    step(21, 0, 0, mk(1, 5'd5, 5'd3, 0, 1, 1, OP_LOAD, 5'd5, 0, 0, 0), NONE);
    step(22, 0, 0, mk(1, 5'd5, 5'd5, 1, 1, 1, OP_ALU, 5'd5, 0, 0, 0), NONE);
    step(23, 0, 0, mk(0, 5'd5, 5'd5, 1, 1, 1, OP_LOAD, 5'd5, 0, 0, 0), NONE);
    // redirect, and redirect without a valid EX instruction
    step(30, 0, 0, rdr, RDR);
    step(31, 0, 0, mk(0, 5'd0, 5'd0, 0, 0, 0, OP_ALU, 5'd0, 1, 0, 0), NONE);
    // four memory wait cycles
    for (int i = 0; i < 4; i++) step(40 + i, 0, 0, mw, MEMW);
    step(44, 0, 0, mr, NONE);
    step(45, 0, 0, idle, NONE);
    // memory wait + redirect + load-use together
    step(50, 0, 0, all3, MEMW);
    step(51, 0, 0, all3, MEMW);
    step(52, 0, 0, mk(1, 5'd5, 5'd2, 1, 1, 1, OP_LOAD, 5'd5, 1, 1, 1), RDR);
    step(53, 0, 0, idle, NONE);
    // reset mid MEM_WAIT with a pending redirect
    step(60, 0, 0, all3, MEMW);
    step(61, 0, 1, all3, NONE);
    step(62, 0, 0, idle, NONE);
    step(63, 0, 0, mw, MEMW);
    step(64, 0, 0, mr, NONE);
    step(65, 0, 0, idle, NONE);
    // dut1: three-cycle flush, redirect during FLUSH is ignored
    step(70, 1, 0, rdr, RDR);
    step(71, 1, 0, rdr, FL);
    step(72, 1, 0, idle, FL);
    step(73, 1, 0, idle, NONE);
    // dut1: two-cycle load-use stall
    step(80, 1, 0, lu5, LUS);
    step(81, 1, 0, idle, LUS);
    step(82, 1, 0, idle, NONE);
    // dut1: memory wait interrupts LU_STALL; stall counter saturates at 3
    step(90, 1, 0, lu5, LUS);
    step(91, 1, 0, mw, MEMW);
    step(92, 1, 0, mr, NONE);
    step(93, 1, 0, idle, NONE);
    // dut1: pending redirect released by mem_ready, then more redirects saturate flush_cnt
    step(100, 1, 0, mk(0, 5'd0, 5'd0, 0, 0, 1, OP_ALU, 5'd3, 1, 1, 0), MEMW);
    step(101, 1, 0, mr, RDR);
    step(102, 1, 0, idle, FL);
    step(103, 1, 0, idle, FL);
    for (int k = 0; k < 2; k++) begin
      step(110 + 4 * k, 1, 0, rdr, RDR);
      step(111 + 4 * k, 1, 0, idle, FL);
      step(112 + 4 * k, 1, 0, idle, FL);
      step(113 + 4 * k, 1, 0, idle, NONE);
    end

    @(negedge clk);
    #1;
    n_chk++;
    if (expq.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard drain: got %0d entries left expected 0", expq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
